// File: rtl/fifo_burst_writer.sv
// rtl/fifo_burst_writer.sv - burst writer that streams payload words into an async FIFO and appends an XOR checksum trailer
module fifo_burst_writer #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clkw,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  input  logic              fifo_full,
  output logic              fifo_wt,
  output logic [DATA_W-1:0] fifo_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_written
);

  // Counter wide enough to hold the value TIMEOUT itself.
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAYLOAD,
    S_TRAILER,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q,     state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] checksum_q,  checksum_d;
  logic [TMO_W-1:0]  tmo_q,       tmo_d;
  logic [15:0]       words_q,     words_d;
  logic [TMO_W-1:0]  tmo_inc;

  assign tmo_inc       = tmo_q + 1'b1;
  assign words_written = words_q;

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clkw or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      checksum_q  <= '0;
      tmo_q       <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      checksum_q  <= checksum_d;
      tmo_q       <= tmo_d;
      words_q     <= words_d;
    end
  end

  // Next-state and datapath updates; a stalled-by-full cycle leaves the timeout counter alone.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    checksum_d  = checksum_q;
    tmo_d       = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = burst_len;
          checksum_d  = '0;
          tmo_d       = '0;
          state_d     = (burst_len == '0) ? S_TRAILER : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (fifo_wt) begin
          remaining_d = remaining_q - 1'b1;
          checksum_d  = checksum_q ^ src_data;
          tmo_d       = '0;
          if (remaining_q == LEN_W'(1)) begin
            state_d = S_TRAILER;
          end
        end else if (!src_valid) begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_W'(TIMEOUT)) begin
            state_d = S_ERR;
          end
        end
      end
      S_TRAILER: begin
        if (fifo_wt) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating count of every FIFO write, trailer included.
  always_comb begin
    words_d = words_q;
    if (fifo_wt && (words_q != 16'hFFFF)) begin
      words_d = words_q + 16'd1;
    end
  end

  // Outputs decoded from the current state; the FIFO is never strobed while full.
  always_comb begin
    src_ready = 1'b0;
    fifo_wt   = 1'b0;
    fifo_data = '0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      S_PAYLOAD: begin
        src_ready = !fifo_full;
        fifo_wt   = src_valid && !fifo_full;
        fifo_data = src_data;
        busy      = 1'b1;
      end
      S_TRAILER: begin
        fifo_wt   = !fifo_full;
        fifo_data = checksum_q;
        busy      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/fifo_burst_writer.md
FIFO_BURST_WRITER -- requirements
Module: fifo_burst_writer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the word width of src_data and fifo_data.
REQ-002 Parameter LEN_W, default 4, SHALL set the width of burst_len.
REQ-003 Parameter TIMEOUT, default 16, SHALL set the number of consecutive idle source cycles that abort a burst.
REQ-004 clkw  input  1  write-domain clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  burst request, sampled only in IDLE.
REQ-007 burst_len  input  LEN_W  payload word count, latched with start.
REQ-008 src_valid  input  1  upstream word available.
REQ-009 src_data  input  DATA_W  upstream word.
REQ-010 src_ready  output  1  upstream word accepted this cycle when src_valid=1.
REQ-011 fifo_full  input  1  full flag from the async FIFO write side.
REQ-012 fifo_wt  output  1  FIFO write strobe.
REQ-013 fifo_data  output  DATA_W  FIFO write data.
REQ-014 busy  output  1  high in PAYLOAD and TRAILER.
REQ-015 done  output  1  one-cycle pulse on burst completion.
REQ-016 err  output  1  one-cycle pulse on timeout abort.
REQ-017 words_written  output  16  running count of FIFO writes since reset, saturating at 0xFFFF.

Function
REQ-018 The FSM SHALL have states IDLE, PAYLOAD, TRAILER, DONE and ERR.
REQ-019 In IDLE, start=1 SHALL latch burst_len into remaining, clear checksum to 0, clear the timeout counter, and go to PAYLOAD; if burst_len=0, it SHALL go to TRAILER instead.
REQ-020 start in any state other than IDLE SHALL be ignored.
REQ-021 In PAYLOAD: src_ready = !fifo_full; fifo_wt = src_valid & !fifo_full; fifo_data = src_data (all combinational).
REQ-022 Each PAYLOAD write SHALL decrement remaining and XOR src_data into checksum; the write with remaining=1 SHALL transition to TRAILER.
REQ-023 In TRAILER: fifo_wt = !fifo_full; fifo_data = checksum; src_ready = 0. Once the write occurs, the FSM SHALL go to DONE.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 In PAYLOAD, the timeout counter SHALL increment each cycle with src_valid=0 and SHALL clear on every accepted word.
REQ-026 A cycle with src_valid=1 and fifo_full=1 SHALL hold the timeout counter unchanged.
REQ-027 When the timeout counter reaches TIMEOUT, the FSM SHALL go to ERR. ERR SHALL last one cycle with err=1, write no trailer, then return to IDLE.
REQ-028 Words already written before an abort SHALL remain in the FIFO.
REQ-029 fifo_wt and src_ready SHALL be 0 in IDLE, DONE and ERR; fifo_data SHALL be 0 in those states.
REQ-030 fifo_wt SHALL never be 1 while fifo_full=1.
REQ-031 words_written SHALL increment on every fifo_wt=1 cycle, including the trailer, and SHALL hold at 0xFFFF.
REQ-032 Minimum burst latency SHALL be burst_len+2 cycles from the start edge to the done pulse when the source never stalls and the FIFO is never full.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, with remaining=0, checksum=0, timeout counter=0, words_written=0, and all outputs at 0.
REQ-034 Reset asserted mid-burst SHALL abandon the burst with no done, err or trailer; the first start after rst_n rises SHALL be honoured.

Verification
REQ-035 burst_len=3, src words 0x11,0x22,0x33 back-to-back, fifo_full=0 -> FIFO writes 0x11,0x22,0x33,0x00 (trailer); done pulse 5 cycles after start; words_written=4.
REQ-036 burst_len=2, words 0xA5,0x0F, fifo_full=1 for 3 cycles before the second word -> src_ready=0 and fifo_wt=0 during the stall, no err, trailer=0xAA.
REQ-037 burst_len=0 -> single FIFO write of 0x00, then done; src_ready stays 0.
REQ-038 burst_len=4, one word 0x55 then src_valid=0 for 16 cycles -> err pulse, words_written=1, no trailer, FSM back in IDLE.
REQ-039 rst_n pulsed low after 2 of 5 words -> all outputs 0 immediately, no done; a new start with burst_len=1 and word 0x7E -> writes 0x7E,0x7E, then done.
REQ-040 start held high during a busy burst -> only one burst is executed; the next start is accepted the cycle after DONE.
